adsr_env: RTL and testbench
===========================

Name: adsr_env

Overview:
- Per-voice ADSR envelope generator that sits directly upstream of the voice multiplier.
- Produces one envelope level per sample tick, together with a one-cycle valid strobe.
- level drives the multiplier B operand; level_dv drives the multiplier ce, so a gain-scaled sample appears at res_dv LATENCY cycles later.

Parameters:
- LEVEL_W, 8: envelope output width; equals the multiplier WIDTH_B.
- FRAC_W, 8: fractional accumulator bits below the output.
- ACC_W, LEVEL_W+FRAC_W: accumulator width and the width of every rate input (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_tick  in  1  one-cycle pulse per audio sample
- gate  in  1  note on (1) / note off (0); level-sensitive
- attack_rate  in  ACC_W  increment per tick in ATTACK; 0 = instantaneous
- decay_rate  in  ACC_W  decrement per tick in DECAY; 0 = instantaneous
- sustain_level  in  LEVEL_W  sustain target
- release_rate  in  ACC_W  decrement per tick in RELEASE; 0 = instantaneous
- level  out  LEVEL_W  envelope value, acc[ACC_W-1:FRAC_W]
- level_dv  out  1  one-cycle strobe: level is valid (feeds multiplier ce)
- active  out  1  high when state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: state=IDLE, acc=0, level=0, level_dv=0, active=0, gate_q=0.
  - Reset mid-operation aborts the envelope; IDLE holds from the next cycle.
  - If gate is still high after rst falls, the first post-reset cycle sees a rising edge and starts ATTACK.
- Edge detection: gate_q <= gate every cycle.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Gate edges are evaluated every clock, independent of sample_tick:
  - rise from any state -> ATTACK. acc is kept, not zeroed (legato retrigger).
  - fall from ATTACK, DECAY or SUSTAIN -> RELEASE.
  - fall in IDLE or RELEASE: no effect.
- Edge priority: when an edge and sample_tick coincide, the edge transition wins and acc is not updated that tick. level_dv still pulses, carrying the unchanged level.
- On sample_tick with no edge, using ACC_W+1-bit arithmetic:
  - IDLE: acc holds 0.
  - ATTACK: sum = acc + attack_rate. If attack_rate==0, or carry out, or sum==all-ones: acc=all-ones and go to DECAY. Otherwise acc=sum.
  - DECAY: tgt = {sustain_level, FRAC_W'b0}. If decay_rate==0, or acc - decay_rate <= tgt (signed compare, so underflow counts as <=): acc=tgt and go to SUSTAIN. Otherwise acc -= decay_rate.
  - SUSTAIN: acc = tgt each tick, so it tracks live changes to sustain_level.
  - RELEASE: if release_rate==0 or release_rate >= acc: acc=0 and go to IDLE. Otherwise acc -= release_rate.
- Boundary cases:
  - sustain_level = all-ones: DECAY clamps on its first tick.
  - sustain_level = 0: the envelope sits at 0 in SUSTAIN and active stays 1 until gate falls.
- Timing:
  - level_dv is sample_tick delayed by exactly 1 clock; it is 0 during and after rst.
  - level is registered and reflects acc after the tick update, valid in the same cycle as level_dv.
  - active is registered from the state.
- Rate inputs are sampled on the tick cycle; no holding requirement between ticks.

Decomposition:
- Shared header adsr_defs.vh holds:
  - state encoding localparams (3-bit: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4);
  - the default widths, so voice and mixer blocks agree with the multiplier widths.
- One natural sub-module: env_sat_step.
  - Combinational saturating add/subtract-to-target.
  - Inputs: acc, rate, direction, target.
  - Outputs: next_acc, reached flag.
  - Used by ATTACK, DECAY and RELEASE.

Test Plan (LEVEL_W=8, FRAC_W=8):
- Attack: rst 2 cycles, gate=1, attack_rate=0x1000, one tick every 4 clocks -> level 0x10, 0x20 ... 0xF0 on ticks 1-15. Tick 16 gives level=0xFF and state DECAY. level_dv lags every tick by 1 clock.
- Decay/sustain: from 0xFFFF with decay_rate=0x0800, sustain=0x80 -> tick 15 gives acc=0x87FF (level 0x87); tick 16 clamps to level=0x80 in SUSTAIN. Changing sustain to 0x40 gives level 0x40 on the next tick.
- Release to idle: gate falls in SUSTAIN at 0x8000, release_rate=0x1000 -> levels 0x70 ... 0x10, then tick 8 gives level=0x00, active=0, state IDLE.
- Instant rates and retrigger: attack_rate=0 -> level 0xFF on the first tick. Gate 1->0->1 mid-RELEASE at level 0x50 -> ATTACK resumes from 0x50, not from 0.
- Coincident edge and reset: gate rises in the same cycle as sample_tick -> level_dv pulses with the old level and the state changes. rst asserted mid-ATTACK while gate is held high -> level=0 and level_dv=0 during rst, then ATTACK restarts on the first cycle after rst falls.

Source files
------------

// File: rtl/adsr_env_pkg.sv
// Shared definitions for the ADSR envelope voice path: default widths that
// keep voice, mixer and multiplier blocks in agreement, the 3-bit state
// encoding, and a small state-classification helper.
package adsr_env_pkg;

    // Default envelope widths; LEVEL_W matches the multiplier B operand.
    localparam int DEF_LEVEL_W = 8;
    localparam int DEF_FRAC_W  = 8;

    // Envelope state encoding.
    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // True for the states in which a falling gate starts the release.
    function automatic logic is_gated(input logic [2:0] st);
        return (st == ST_ATTACK) || (st == ST_DECAY) || (st == ST_SUSTAIN);
    endfunction

endpackage

// File: rtl/env_sat_step.sv
// Combinational saturating step toward a target value. Moving up, the sum
// is clamped to the target once it would reach or pass it (including carry
// out of the accumulator). Moving down, the difference is evaluated one bit
// wider and signed so that an underflow also counts as reaching the target.
// A zero rate means "reach the target immediately".
module env_sat_step #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] rate,
    input  logic             dir_up,
    input  logic [ACC_W-1:0] target,
    output logic [ACC_W-1:0] next_acc,
    output logic             reached
);

    // Upward step: returns {reached, next value}.
    function automatic logic [ACC_W:0] sat_up(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] r,
        input logic [ACC_W-1:0] t
    );
        logic [ACC_W:0] sum;
        logic           hit;
        sum = {1'b0, a} + {1'b0, r};
        hit = (r == '0) || (sum >= {1'b0, t});
        return hit ? {1'b1, t} : {1'b0, sum[ACC_W-1:0]};
    endfunction

    // Downward step: returns {reached, next value}.
    function automatic logic [ACC_W:0] sat_down(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] r,
        input logic [ACC_W-1:0] t
    );
        logic signed [ACC_W:0] diff;
        logic signed [ACC_W:0] tgt;
        logic                  hit;
        diff = $signed({1'b0, a}) - $signed({1'b0, r});
        tgt  = $signed({1'b0, t});
        hit  = (r == '0) || (diff <= tgt);
        return hit ? {1'b1, t} : {1'b0, diff[ACC_W-1:0]};
    endfunction

    logic [ACC_W:0] step;

    // Select the step direction and split the packed result.
    always_comb begin
        step = '0;
        if (dir_up) begin
            step = sat_up(acc, rate, target);
        end else begin
            step = sat_down(acc, rate, target);
        end
        reached  = step[ACC_W];
        next_acc = step[ACC_W-1:0];
    end

endmodule

// File: rtl/adsr_env.sv
// Per-voice ADSR envelope generator. Gate edges are acted on every clock;
// the accumulator only moves on sample_tick. Each tick yields one level
// sample plus a one-cycle level_dv strobe that drives the downstream
// multiplier clock enable.
module adsr_env
    import adsr_env_pkg::*;
#(
    parameter  int LEVEL_W = DEF_LEVEL_W,
    parameter  int FRAC_W  = DEF_FRAC_W,
    localparam int ACC_W   = LEVEL_W + FRAC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               gate,
    input  logic [ACC_W-1:0]   attack_rate,
    input  logic [ACC_W-1:0]   decay_rate,
    input  logic [LEVEL_W-1:0] sustain_level,
    input  logic [ACC_W-1:0]   release_rate,
    output logic [LEVEL_W-1:0] level,
    output logic               level_dv,
    output logic               active
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic               gate_q;
    logic               rise;
    logic               fall;

    logic [ACC_W-1:0]   sus_tgt;
    logic [ACC_W-1:0]   step_rate;
    logic [ACC_W-1:0]   step_tgt;
    logic               step_up;
    logic [ACC_W-1:0]   step_next;
    logic               step_reached;

    assign rise    = gate & ~gate_q;
    assign fall    = ~gate & gate_q;
    assign sus_tgt = {sustain_level, {FRAC_W{1'b0}}};

    // Route the rate and target of the current segment into the step unit.
    always_comb begin
        step_up   = 1'b0;
        step_rate = release_rate;
        step_tgt  = '0;
        case (state)
            ST_ATTACK: begin
                step_up   = 1'b1;
                step_rate = attack_rate;
                step_tgt  = '1;
            end
            ST_DECAY: begin
                step_rate = decay_rate;
                step_tgt  = sus_tgt;
            end
            default: begin
                step_rate = release_rate;
                step_tgt  = '0;
            end
        endcase
    end

    env_sat_step #(
        .ACC_W (ACC_W)
    ) u_step (
        .acc      (acc),
        .rate     (step_rate),
        .dir_up   (step_up),
        .target   (step_tgt),
        .next_acc (step_next),
        .reached  (step_reached)
    );

    // Next state and accumulator: gate edges take priority over the tick,
    // and a retrigger keeps the current accumulator for a legato attack.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        if (rise) begin
            state_nxt = ST_ATTACK;
        end else if (fall && is_gated(state)) begin
            state_nxt = ST_RELEASE;
        end else if (sample_tick) begin
            case (state)
                ST_IDLE: begin
                    acc_nxt = '0;
                end
                ST_ATTACK: begin
                    acc_nxt = step_next;
                    if (step_reached) begin
                        state_nxt = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    acc_nxt = step_next;
                    if (step_reached) begin
                        state_nxt = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    acc_nxt = sus_tgt;
                end
                ST_RELEASE: begin
                    acc_nxt = step_next;
                    if (step_reached) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                end
            endcase
        end
    end

    // State, accumulator and registered outputs; level and active follow the
    // post-update values so they line up with the level_dv strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            gate_q   <= 1'b0;
            level    <= '0;
            level_dv <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            gate_q   <= gate;
            level    <= acc_nxt[ACC_W-1:FRAC_W];
            level_dv <= sample_tick;
            active   <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_adsr_env.sv
// Directed-vector bench for adsr_env: each tick pushes its hand-computed
// level/active pair into a queue, and a monitor pops and compares whenever
// level_dv strobes.
module tb_adsr_env;

    localparam int LEVEL_W = 8;
    localparam int FRAC_W  = 8;
    localparam int ACC_W   = LEVEL_W + FRAC_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_tick = 1'b0;
    logic               gate = 1'b0;
    logic [ACC_W-1:0]   attack_rate = '0;
    logic [ACC_W-1:0]   decay_rate = '0;
    logic [LEVEL_W-1:0] sustain_level = '0;
    logic [ACC_W-1:0]   release_rate = '0;
    logic [LEVEL_W-1:0] level;
    logic               level_dv;
    logic               active;

    typedef struct {
        logic [LEVEL_W-1:0] lvl;
        logic               act;
        string              tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    adsr_env #(
        .LEVEL_W (LEVEL_W),
        .FRAC_W  (FRAC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .level         (level),
        .level_dv      (level_dv),
        .active        (active)
    );

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every level_dv strobe consumes one expected sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (level_dv === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_dv: level_dv with level 0x%0h, expected no strobe", level);
                end else begin
                    e = q.pop_front();
                    chk({e.tag, "_level"}, int'(level), int'(e.lvl));
                    chk({e.tag, "_active"}, int'(active), int'(e.act));
                end
            end
        end
    end

    // Issue one tick (one every 4 clocks) carrying its expected result.
    task automatic tick(input logic [LEVEL_W-1:0] lvl, input logic act, input string tag);
        exp_t e;
        @(negedge clk);
        sample_tick = 1'b1;
        e.lvl = lvl;
        e.act = act;
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Change gate and let one clock process the edge with no tick.
    task automatic set_gate(input logic v);
        @(negedge clk);
        gate = v;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time 200000 reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   lv;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_level", int'(level), 0);
        chk("reset_dv", int'(level_dv), 0);
        chk("reset_active", int'(active), 0);
        rst = 1'b0;

        attack_rate   = 16'h1000;
        decay_rate    = 16'h0800;
        sustain_level = 8'h80;
        release_rate  = 16'h1000;

        // Attack ramp, then saturation to full scale into DECAY
        set_gate(1'b1);
        for (int k = 1; k <= 15; k++) tick(8'(k * 16), 1'b1, "attack");
        tick(8'hFF, 1'b1, "attack_top");

        // Decay from 0xFFFF in 0x0800 steps, clamp at sustain 0x80
        for (int k = 1; k <= 15; k++) begin
            lv = (32'hFFFF - k * 32'h0800) >> 8;
            tick(8'(lv), 1'b1, "decay");
        end
        tick(8'h80, 1'b1, "decay_clamp");

        // Sustain tracks live sustain_level
        @(negedge clk);
        sustain_level = 8'h40;
        tick(8'h40, 1'b1, "sustain_40");
        sustain_level = 8'h80;
        tick(8'h80, 1'b1, "sustain_80");

        // Release from 0x8000 to idle
        set_gate(1'b0);
        for (int k = 1; k <= 7; k++) tick(8'(8'h80 - k * 16), 1'b1, "release");
        tick(8'h00, 1'b0, "release_end");
        tick(8'h00, 1'b0, "idle_tick");

        // Instantaneous attack, instantaneous decay to sustain 0x60
        attack_rate = '0;
        set_gate(1'b1);
        tick(8'hFF, 1'b1, "attack_instant");
        decay_rate    = '0;
        sustain_level = 8'h60;
        tick(8'h60, 1'b1, "decay_instant");

        // Release one step to 0x50, then retrigger keeps the level
        set_gate(1'b0);
        tick(8'h50, 1'b1, "release_to_50");
        set_gate(1'b1);
        attack_rate = 16'h1000;
        tick(8'h60, 1'b1, "legato_attack");

        // Coincident rising edge and tick: old level, no accumulator step
        set_gate(1'b0);
        @(negedge clk);
        gate        = 1'b1;
        sample_tick = 1'b1;
        e.lvl = 8'h60;
        e.act = 1'b1;
        e.tag = "edge_tick";
        q.push_back(e);
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        tick(8'h70, 1'b1, "after_edge_attack");

        // Reset mid-ATTACK with gate held high, including a tick during reset
        @(negedge clk);
        rst         = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("midrst_level", int'(level), 0);
        chk("midrst_dv", int'(level_dv), 0);
        chk("midrst_active", int'(active), 0);
        @(negedge clk);
        chk("midrst_dv2", int'(level_dv), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_active", int'(active), 1);
        chk("post_rst_level", int'(level), 0);
        tick(8'h10, 1'b1, "post_rst_attack");

        // Full-scale sustain clamps on the first decay tick; zero sustain stays active
        attack_rate   = '0;
        tick(8'hFF, 1'b1, "attack_instant2");
        sustain_level = 8'hFF;
        decay_rate    = 16'h0100;
        tick(8'hFF, 1'b1, "decay_full_clamp");
        sustain_level = 8'h00;
        tick(8'h00, 1'b1, "sustain_zero");
        tick(8'h00, 1'b1, "sustain_zero2");
        set_gate(1'b0);
        tick(8'h00, 1'b0, "release_from_zero");

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
